// File: rtl/atm_txn_engine_if.sv
// Request/response handshake bundle for atm_txn_engine.
// The master drives requests and accepts responses; the slave is the engine.
interface atm_txn_engine_if #(
    parameter int ACCT_W = 4,
    parameter int AMT_W  = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        select;
    logic [ACCT_W-1:0] origin_account_number;
    logic [ACCT_W-1:0] purpose_account_number;
    logic [AMT_W-1:0]  transfer_amount;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        result;
    logic [AMT_W-1:0]  inventory_result;

    modport master (
        output req_valid, select, origin_account_number, purpose_account_number,
               transfer_amount, resp_ready,
        input  req_ready, resp_valid, result, inventory_result
    );

    modport slave (
        input  req_valid, select, origin_account_number, purpose_account_number,
               transfer_amount, resp_ready,
        output req_ready, resp_valid, result, inventory_result
    );
endinterface

// File: rtl/atm_txn_engine.sv
// Clocked ATM transaction engine: balance register file plus IDLE/LOOKUP/EXEC/RESP FSM.
// Define ATM_TXN_STATS_EN to add saturating ok_count/fail_count outputs.
module atm_txn_engine #(
    parameter int N_ACCOUNTS   = 12,
    parameter int ACCT_W       = 4,
    parameter int AMT_W        = 10,
    parameter int INIT_BALANCE = 100
) (
    input  logic              clk,
    input  logic              rst,
    atm_txn_engine_if.slave   bus
`ifdef ATM_TXN_STATS_EN
    ,
    output logic [15:0]       ok_count,
    output logic [15:0]       fail_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;

    localparam logic [1:0]        RES_OK  = 2'b00;
    localparam logic [1:0]        RES_NSF = 2'b01;
    localparam logic [1:0]        RES_INV = 2'b10;
    localparam logic [1:0]        RES_OVF = 2'b11;
    localparam logic [ACCT_W:0]   N_LIM   = (ACCT_W+1)'(N_ACCOUNTS);
    localparam logic [AMT_W:0]    AMT_MAX = {1'b0, {AMT_W{1'b1}}};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state;
    logic [AMT_W-1:0]  bal [N_ACCOUNTS];

    logic [1:0]        sel_p0;
    logic [ACCT_W-1:0] org_p0, pur_p0;
    logic [AMT_W-1:0]  amt_p0;
    logic              org_ok_p1, pur_ok_p1;
    logic [AMT_W-1:0]  org_bal_p1, pur_bal_p1;

    logic              org_ok, pur_ok;
    logic [1:0]        res_x;
    logic [AMT_W-1:0]  inv_x, org_new, pur_new;
    logic              org_we, pur_we;

    assign org_ok = {1'b0, org_p0} < N_LIM;
    assign pur_ok = {1'b0, pur_p0} < N_LIM;

    // Stage p0: capture request on accept; stage p1: range check and balance read
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid && bus.req_ready) begin
            sel_p0 <= bus.select;
            org_p0 <= bus.origin_account_number;
            pur_p0 <= bus.purpose_account_number;
            amt_p0 <= bus.transfer_amount;
        end
        if (state == LOOKUP) begin
            org_ok_p1  <= org_ok;
            pur_ok_p1  <= pur_ok;
            org_bal_p1 <= org_ok ? bal[org_p0] : '0;
            pur_bal_p1 <= pur_ok ? bal[pur_p0] : '0;
        end
    end

    // Stage p2: decide the outcome from the looked-up balances
    always_comb begin
        res_x   = RES_OK;
        inv_x   = '0;
        org_we  = 1'b0;
        pur_we  = 1'b0;
        org_new = org_bal_p1 - amt_p0;
        pur_new = pur_bal_p1 + amt_p0;
        unique case (sel_p0)
            2'b00: ;
            2'b01: begin
                if (!org_ok_p1) res_x = RES_INV;
                else            inv_x = org_bal_p1;
            end
            2'b10: begin
                if (!org_ok_p1) begin
                    res_x = RES_INV;
                end else if (amt_p0 > org_bal_p1) begin
                    res_x = RES_NSF;
                    inv_x = org_bal_p1;
                end else begin
                    org_we = 1'b1;
                    inv_x  = org_new;
                end
            end
            default: begin
                if (!org_ok_p1 || !pur_ok_p1) begin
                    res_x = RES_INV;
                    inv_x = org_ok_p1 ? org_bal_p1 : '0;
                end else if (org_p0 == pur_p0) begin
                    inv_x = org_bal_p1;
                end else if (amt_p0 > org_bal_p1) begin
                    res_x = RES_NSF;
                    inv_x = org_bal_p1;
                end else if (({1'b0, pur_bal_p1} + {1'b0, amt_p0}) > AMT_MAX) begin
                    res_x = RES_OVF;
                    inv_x = org_bal_p1;
                end else begin
                    org_we = 1'b1;
                    pur_we = 1'b1;
                    inv_x  = org_new;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            bus.req_ready        <= 1'b1;
            bus.resp_valid       <= 1'b0;
            bus.result           <= RES_OK;
            bus.inventory_result <= '0;
            for (int i = 0; i < N_ACCOUNTS; i++) bal[i] <= AMT_W'(INIT_BALANCE);
`ifdef ATM_TXN_STATS_EN
            ok_count   <= '0;
            fail_count <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= LOOKUP;
                        bus.req_ready <= 1'b0;
                    end
                end
                LOOKUP: state <= EXEC;
                EXEC: begin
                    if (org_we) bal[org_p0] <= org_new;
                    if (pur_we) bal[pur_p0] <= pur_new;
                    bus.result           <= res_x;
                    bus.inventory_result <= inv_x;
                    bus.resp_valid       <= 1'b1;
                    state                <= RESP;
`ifdef ATM_TXN_STATS_EN
                    if (sel_p0 != 2'b00) begin
                        if (res_x == RES_OK) ok_count   <= sat_inc(ok_count);
                        else                 fail_count <= sat_inc(fail_count);
                    end
`endif
                end
                default: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_atm_txn_engine.sv
// Self-checking bench for atm_txn_engine: directed steps plus random transactions
// checked against a behavioural balance model.
module tb_atm_txn_engine;
    localparam int N      = 12;
    localparam int ACCT_W = 4;
    localparam int AMT_W  = 10;
    localparam int MAXB   = (1 << AMT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    atm_txn_engine_if #(.ACCT_W(ACCT_W), .AMT_W(AMT_W)) bus ();

`ifdef ATM_TXN_STATS_EN
    logic [15:0] ok_count, fail_count;
    int m_ok, m_fail;
`endif

    atm_txn_engine #(.N_ACCOUNTS(N), .ACCT_W(ACCT_W), .AMT_W(AMT_W), .INIT_BALANCE(100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ATM_TXN_STATS_EN
        ,
        .ok_count(ok_count),
        .fail_count(fail_count)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int mbal [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mbal[i] = (i < N) ? 100 : 0;
`ifdef ATM_TXN_STATS_EN
        m_ok = 0;
        m_fail = 0;
`endif
    endtask

    // Reference: apply one operation to the model, return expected result and inventory
    task automatic model_op(input int sel, input int o, input int p, input int amt,
                            output int res, output int inv);
        bit ov = (o < N);
        bit pv = (p < N);
        res = 0;
        inv = 0;
        case (sel)
            0: ;
            1: if (!ov) res = 2; else inv = mbal[o];
            2: begin
                if (!ov) res = 2;
                else if (amt > mbal[o]) begin res = 1; inv = mbal[o]; end
                else begin mbal[o] -= amt; inv = mbal[o]; end
            end
            default: begin
                if (!ov || !pv) begin res = 2; inv = ov ? mbal[o] : 0; end
                else if (o == p) inv = mbal[o];
                else if (amt > mbal[o]) begin res = 1; inv = mbal[o]; end
                else if (mbal[p] + amt > MAXB) begin res = 3; inv = mbal[o]; end
                else begin mbal[o] -= amt; mbal[p] += amt; inv = mbal[o]; end
            end
        endcase
`ifdef ATM_TXN_STATS_EN
        if (sel != 0) begin
            if (res == 0) m_ok++;
            else m_fail++;
        end
`endif
    endtask

    task automatic drive_req(input int sel, input int o, input int p, input int amt);
        bus.select                 = 2'(sel);
        bus.origin_account_number  = ACCT_W'(o);
        bus.purpose_account_number = ACCT_W'(p);
        bus.transfer_amount        = AMT_W'(amt);
        bus.req_valid              = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid              = 1'b0;
        bus.select                 = 2'($urandom);
        bus.origin_account_number  = ACCT_W'($urandom);
        bus.purpose_account_number = ACCT_W'($urandom);
        bus.transfer_amount        = AMT_W'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.req_ready !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 1);
    endtask

    task automatic txn(input int sel, input int o, input int p, input int amt, input int hold);
        int er, ei, k;
        wait_idle();
        model_op(sel, o, p, amt, er, ei);
        drive_req(sel, o, p, amt);
        @(negedge clk);
        check("lat_lookup_valid", 32'(bus.resp_valid), 0);
        @(negedge clk);
        check("lat_exec_valid", 32'(bus.resp_valid), 0);
        @(negedge clk);
        check("lat_resp_valid", 32'(bus.resp_valid), 1);
        k = 0;
        while (bus.resp_valid !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("resp_ready_low", 32'(bus.req_ready), 0);
        check($sformatf("result sel=%0d o=%0d p=%0d amt=%0d", sel, o, p, amt), 32'(bus.result), 32'(er));
        check($sformatf("inventory sel=%0d o=%0d p=%0d amt=%0d", sel, o, p, amt),
              32'(bus.inventory_result), 32'(ei));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.resp_valid), 1);
            check("stall_result", 32'(bus.result), 32'(er));
            check("stall_inventory", 32'(bus.inventory_result), 32'(ei));
            check("stall_req_ready", 32'(bus.req_ready), 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("post_resp_valid", 32'(bus.resp_valid), 0);
        check("post_req_ready", 32'(bus.req_ready), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int amt, o, p, sel;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        bus.select = '0;
        bus.origin_account_number = '0;
        bus.purpose_account_number = '0;
        bus.transfer_amount = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 1);
        check("reset_resp_valid", 32'(bus.resp_valid), 0);
        check("reset_result", 32'(bus.result), 0);
        check("reset_inventory", 32'(bus.inventory_result), 0);

        txn(1, 3, 0, 0, 0);
        txn(2, 5, 0, 40, 0);
        txn(2, 5, 0, 61, 0);
        txn(1, 5, 0, 0, 0);
        txn(3, 2, 7, 100, 0);
        txn(1, 7, 0, 0, 0);
        txn(3, 2, 7, 1, 0);
        txn(2, 1, 0, 0, 0);
        txn(0, 14, 15, 77, 0);

        for (int k = 1; k < N; k++) begin
            if (k != 9 && mbal[0] < 1000) begin
                amt = (mbal[k] < 1000 - mbal[0]) ? mbal[k] : 1000 - mbal[0];
                if (amt > 0) txn(3, k, 0, amt, 0);
            end
        end
        check("chain_origin_balance", 32'(mbal[0]), 1000);
        txn(3, 0, 9, 1000, 0);
        txn(1, 0, 0, 0, 0);
        txn(1, 9, 0, 0, 0);
        txn(3, 12, 1, 5, 0);
        txn(3, 1, 15, 5, 0);
        txn(3, 4, 4, 50, 0);
        txn(1, 6, 0, 0, 5);

        do_reset();
        drive_req(2, 4, 0, 30);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_exec_req_ready", 32'(bus.req_ready), 1);
        check("rst_exec_resp_valid", 32'(bus.resp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_exec_idle_resp", 32'(bus.resp_valid), 0);
        txn(1, 4, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            o = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
            p = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
            case ($urandom_range(0, 3))
                0: amt = $urandom_range(0, 60);
                1: amt = mbal[o];
                2: amt = $urandom_range(0, MAXB);
                default: amt = (mbal[o] < MAXB) ? mbal[o] + 1 : MAXB;
            endcase
            txn(sel, o, p, amt, $urandom_range(0, 2));
        end

`ifdef ATM_TXN_STATS_EN
        do_reset();
        check("stats_reset_ok", 32'(ok_count), 0);
        check("stats_reset_fail", 32'(fail_count), 0);
        txn(1, 1, 0, 0, 0);
        txn(2, 1, 0, 10, 0);
        txn(3, 1, 2, 5, 0);
        txn(2, 3, 0, 1000, 0);
        txn(1, 13, 0, 0, 0);
        txn(0, 0, 0, 0, 0);
        check("stats_ok_count", 32'(ok_count), 32'(m_ok));
        check("stats_fail_count", 32'(fail_count), 32'(m_fail));
        check("stats_ok_three", 32'(ok_count), 3);
        check("stats_fail_two", 32'(fail_count), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
